elevator_request_scheduler: RTL and testbench
=============================================

Name: elevator_request_scheduler

Overview:
- Collects floor-call button presses into a pending-request vector.
- Serves calls in LOOK order: continue in the current direction while calls remain ahead, then reverse.
- Drives the target floor into the elevator motion FSM, and runs the door-dwell timer on arrival.
- Sits between the ui_in call buttons and elevator_state_machine.requested_floor; current_floor and the idle flag come back from that FSM.

Parameters:
- NUM_FLOORS, 6, number of served floors (0..NUM_FLOORS-1); max 16.
- DOOR_TICKS, 10000000, clk cycles door_open stays high per stop; min 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- call_btn  input  NUM_FLOORS  level-sensitive call buttons, bit i = floor i.
- current_floor  input  4  car position reported by the motion FSM.
- car_idle  input  1  1 = car stationary (motion FSM in idle state).
- target_floor  output  4  floor requested from the motion FSM.
- door_open  output  1  door dwell in progress.
- dir_up  output  1  current sweep direction, 1 = up.
- pending  output  NUM_FLOORS  latched outstanding calls.
- busy  output  1  1 when state != IDLE.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All state changes on posedge clk.
- Reset values: state=IDLE, pending=0, target_floor=0, door_open=0, dir_up=1, busy=0, door counter=0.
- Request latch: pending[i] is set the cycle after call_btn[i] is sampled high. Set stays set until floor i is served.
- Set/clear collision:
  - Press at the floor being cleared in the same cycle: clear wins.
  - Press at the served floor during DOOR: absorbed and restarts the dwell counter.
  - Press at any other floor: always latched.
- Selection function (combinational), based on current_floor (cf) and dir_up:
  - "ahead" = nearest pending floor > cf if dir_up, or < cf if !dir_up.
  - "behind" = nearest pending floor in the opposite direction.
  - Pick ahead if one exists; else pick behind and flip dir_up.
  - pending[cf] is handled separately, as a here-request.
- States:
  - IDLE:
    - target_floor held = cf.
    - If pending[cf]: clear it, go to DOOR.
    - Else if pending != 0: register the selected floor into target_floor, update dir_up, go to SERVE.
    - Latency: pending visible at cycle N, target_floor valid at N+1.
  - SERVE:
    - Arrival = car_idle && cf == target_floor. On arrival: clear pending[target_floor], go to DOOR.
    - Retarget: if a pending floor strictly between cf and target_floor in the dir_up direction appears, target_floor moves to it the next cycle. No other retarget; dir_up is frozen while in SERVE.
  - DOOR:
    - door_open=1 for exactly DOOR_TICKS cycles; counter restarts on an absorbed press.
    - Then door_open=0. Go to IDLE if pending==0, else run selection and go to SERVE.
    - target_floor is unchanged during DOOR.
- Floor bounds: current_floor >= NUM_FLOORS is treated as no-ahead in the up direction. target_floor never exceeds NUM_FLOORS-1.
- Reset mid-operation clears pending and door_open immediately (asynchronous), with no pulse completion.
- busy = (state != IDLE), registered with the state.

Decomposition:
- elevator_pkg:
  - Constant MAX_FLOORS=16 and floor width 4.
  - State enum IDLE/SERVE/DOOR, encoded 2'b00/2'b01/2'b10; 2'b11 recovers to IDLE.
  - Function/constant for the door counter width, $clog2(DOOR_TICKS+1).
- Sub-module elevator_look_select: purely combinational.
  - Inputs: pending, current_floor, dir_up.
  - Outputs: sel_floor, sel_valid, sel_dir_up, here_hit.
  - Shared by the IDLE, SERVE-retarget and DOOR-exit paths.
- Top scheduler holds the registers: pending, state, target_floor, dir_up, door counter.

Test Plan (DOOR_TICKS=4; bench car model moves 1 floor every 3 cycles, car_idle=1 when cf==target):
- Reset then idle: no buttons for 20 cycles -> target_floor=0, busy=0, door_open=0, pending=0.
- Single call: cf=0, pulse call_btn[3] -> pending=001000 next cycle, target_floor=3 one cycle later, dir_up=1. On arrival, pending[3] clears, door_open high exactly 4 cycles, then IDLE.
- LOOK order: cf=2, dir_up=1, calls {0,4,5} latched together -> served 4, 5, then dir_up=0, then 0. Door pulses at each stop.
- Retarget: heading 0→5, assert call_btn[3] while cf=1 -> target_floor becomes 3 the next cycle. Stops at 3, then resumes to 5.
- Here-request and absorb: car idle at 2, press call_btn[2] -> DOOR entered next cycle, pending[2] never stays set. Press call_btn[2] again on dwell cycle 3 -> door_open total 3+4 cycles.
- Async reset: assert rst_n=0 mid-DOOR with calls {1,4} pending -> door_open, pending, busy drop to 0 without waiting for a clock. After release, target_floor=0, dir_up=1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and sizing helpers for the elevator request scheduler slice.
package elevator_pkg;
   localparam int MAX_FLOORS = 16;
   localparam int FLOOR_W    = 4;

   typedef logic [FLOOR_W-1:0] floor_t;

   // 2'b11 is not a legal state; the scheduler steers it back to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SERVE = 2'b01,
      DOOR  = 2'b10
   } state_t;

   function automatic int door_cnt_w(input int ticks);
      return (ticks < 1) ? 1 : $clog2(ticks + 1);
   endfunction
endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Call-button / motion-FSM handshake bundle; master is the scheduler side.
interface elevator_request_scheduler_if
   import elevator_pkg::*;
   #(parameter int NUM_FLOORS = 6);
   logic [NUM_FLOORS-1:0] call_btn;
   floor_t                current_floor;
   logic                  car_idle;
   floor_t                target_floor;
   logic                  door_open;
   logic                  dir_up;
   logic [NUM_FLOORS-1:0] pending;
   logic                  busy;

   modport master (input  call_btn, current_floor, car_idle,
                   output target_floor, door_open, dir_up, pending, busy);
   modport slave  (output call_btn, current_floor, car_idle,
                   input  target_floor, door_open, dir_up, pending, busy);
endinterface

// File: rtl/elevator_look_select.sv
// LOOK selection: nearest pending floor ahead, else nearest behind with a direction flip.
module elevator_look_select
   import elevator_pkg::*;
   #(parameter int NUM_FLOORS = 6)
   (
   input  logic [NUM_FLOORS-1:0] pending,
   input  floor_t                current_floor,
   input  logic                  dir_up,
   output floor_t                sel_floor,
   output logic                  sel_valid,
   output logic                  sel_dir_up,
   output logic                  here_hit
   );

   floor_t up_floor, dn_floor;
   logic   up_found, dn_found;

   // Scan order makes the last hit the nearest one in each direction.
   always_comb begin
      up_found = 1'b0;
      dn_found = 1'b0;
      up_floor = '0;
      dn_floor = '0;
      here_hit = 1'b0;
      for (int i = NUM_FLOORS-1; i >= 0; i--) begin
         if (pending[i] && floor_t'(i) > current_floor) begin
            up_found = 1'b1;
            up_floor = floor_t'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && floor_t'(i) < current_floor) begin
            dn_found = 1'b1;
            dn_floor = floor_t'(i);
         end
         if (pending[i] && floor_t'(i) == current_floor) here_hit = 1'b1;
      end
   end

   always_comb begin
      sel_valid = up_found | dn_found;
      if (dir_up) begin
         sel_dir_up = up_found;
         sel_floor  = up_found ? up_floor : dn_floor;
      end else begin
         sel_dir_up = !dn_found;
         sel_floor  = dn_found ? dn_floor : up_floor;
      end
   end
endmodule

// File: rtl/elevator_request_scheduler.sv
// Latches floor calls, serves them in LOOK order and times the door dwell at each stop.
module elevator_request_scheduler
   import elevator_pkg::*;
   #(parameter int NUM_FLOORS = 6,
     parameter int DOOR_TICKS = 10000000)
   (
   input logic                         clk,
   input logic                         rst_n,
   elevator_request_scheduler_if.master bus
   );

   localparam int               CNT_W     = door_cnt_w(DOOR_TICKS);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DOOR_TICKS - 1);
   localparam floor_t           TOP_FLOOR = floor_t'(NUM_FLOORS - 1);

   state_t                state, state_nxt;
   logic [NUM_FLOORS-1:0] pending, clr_mask;
   floor_t                target, target_nxt, clr_floor, sel_floor, cf;
   logic                  dir_up, dir_nxt, clr_en, absorb, arrive, retarget;
   logic                  sel_valid, sel_dir_up, here_hit;
   logic [CNT_W-1:0]      cnt, cnt_nxt;

   assign cf = bus.current_floor;

   elevator_look_select #(.NUM_FLOORS(NUM_FLOORS)) u_sel (
      .pending      (pending),
      .current_floor(cf),
      .dir_up       (dir_up),
      .sel_floor    (sel_floor),
      .sel_valid    (sel_valid),
      .sel_dir_up   (sel_dir_up),
      .here_hit     (here_hit)
   );

   always_comb begin
      absorb = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (bus.call_btn[i] && floor_t'(i) == target) absorb = 1'b1;
      arrive   = bus.car_idle && (cf == target);
      // Only a floor strictly inside the current leg may pull the target in.
      retarget = sel_valid && (sel_dir_up == dir_up) &&
                 (dir_up ? (sel_floor < target) : (sel_floor > target));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      dir_nxt    = dir_up;
      cnt_nxt    = cnt;
      clr_en     = 1'b0;
      clr_floor  = target;
      case (state)
         IDLE: begin
            target_nxt = (cf > TOP_FLOOR) ? TOP_FLOOR : cf;
            if (here_hit) begin
               clr_en    = 1'b1;
               clr_floor = cf;
               cnt_nxt   = CNT_LOAD;
               state_nxt = DOOR;
            end else if (sel_valid) begin
               target_nxt = sel_floor;
               dir_nxt    = sel_dir_up;
               state_nxt  = SERVE;
            end
         end
         SERVE: begin
            if (arrive) begin
               clr_en    = 1'b1;
               cnt_nxt   = CNT_LOAD;
               state_nxt = DOOR;
            end else if (retarget) begin
               target_nxt = sel_floor;
            end
         end
         DOOR: begin
            // Presses at the open floor never reach pending; they extend the dwell.
            clr_en = 1'b1;
            if (absorb) begin
               cnt_nxt = CNT_LOAD;
            end else if (cnt == '0) begin
               if (sel_valid) begin
                  target_nxt = sel_floor;
                  dir_nxt    = sel_dir_up;
                  state_nxt  = SERVE;
               end else begin
                  state_nxt  = IDLE;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      clr_mask = '0;
      for (int i = 0; i < NUM_FLOORS; i++)
         clr_mask[i] = clr_en && (floor_t'(i) == clr_floor);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         target  <= '0;
         dir_up  <= 1'b1;
         cnt     <= '0;
      end else begin
         pending <= (pending | bus.call_btn) & ~clr_mask;
         target  <= target_nxt;
         dir_up  <= dir_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      bus.busy         = (state != IDLE);
      bus.door_open    = (state == DOOR);
      bus.target_floor = target;
      bus.dir_up       = dir_up;
      bus.pending      = pending;
   end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench: floor-stepping car model, cycle-level behavioural scheduler model, literal pins.
module tb_elevator_request_scheduler;
   localparam int NF = 6;
   localparam int DT = 4;
   localparam int P_IDLE = 0, P_SERVE = 1, P_DOOR = 2;

   typedef struct {
      int          ph;
      logic [NF-1:0] pend;
      int          tgt;
      bit          up;
      int          left;
   } mdl_t;

   logic clk, rst_n;
   elevator_request_scheduler_if #(.NUM_FLOORS(NF)) bus ();

   elevator_request_scheduler #(.NUM_FLOORS(NF), .DOOR_TICKS(DT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.car_idle = (bus.current_floor == bus.target_floor);

   int   checks = 0, failures = 0;
   int   car_cf = 0, mv = 0, cur_len = 0;
   bit   door_q = 0;
   int   stops[$];
   int   lens[$];
   mdl_t m;

   function automatic int nearest(logic [NF-1:0] p, int cf, bit up);
      for (int d = 1; d < 16; d++) begin
         int f = up ? cf + d : cf - d;
         if (f >= 0 && f < NF && p[f]) return f;
      end
      return -1;
   endfunction

   function automatic mdl_t step(mdl_t c, logic [NF-1:0] btn, int cf, bit idle);
      mdl_t n = c;
      logic [NF-1:0] clr = '0;
      int ah = nearest(c.pend, cf, c.up);
      int bh = nearest(c.pend, cf, !c.up);
      bit pick = 0;
      case (c.ph)
         P_IDLE: begin
            n.tgt = (cf < NF) ? cf : NF - 1;
            if (cf < NF && c.pend[cf]) begin
               clr[cf] = 1'b1; n.ph = P_DOOR; n.left = DT;
            end else pick = 1;
         end
         P_SERVE: begin
            if (idle && cf == c.tgt) begin
               clr[c.tgt] = 1'b1; n.ph = P_DOOR; n.left = DT;
            end else if (ah >= 0 && (c.up ? ah < c.tgt : ah > c.tgt)) n.tgt = ah;
         end
         default: begin
            clr[c.tgt] = 1'b1;
            if (btn[c.tgt]) n.left = DT;
            else if (c.left == 1) begin n.ph = P_IDLE; pick = 1; end
            else n.left = c.left - 1;
         end
      endcase
      if (pick && ah >= 0) begin n.tgt = ah; n.ph = P_SERVE; end
      else if (pick && bh >= 0) begin n.tgt = bh; n.up = !c.up; n.ph = P_SERVE; end
      n.pend = (c.pend | btn) & ~clr;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '{P_IDLE, '0, 0, 1'b1, 0};
      else        m <= step(m, bus.call_btn, int'(bus.current_floor), bus.car_idle);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One bench cycle: record door stops, compare against the model, then move the car.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         if (bus.door_open && !door_q) stops.push_back(int'(bus.current_floor));
         if (bus.door_open) cur_len++;
         else if (door_q) begin lens.push_back(cur_len); cur_len = 0; end
         door_q = bus.door_open;
         check("cyc_target",  int'(bus.target_floor), m.tgt);
         check("cyc_door",    int'(bus.door_open), int'(m.ph == P_DOOR));
         check("cyc_busy",    int'(bus.busy), int'(m.ph != P_IDLE));
         check("cyc_dir_up",  int'(bus.dir_up), int'(m.up));
         check("cyc_pending", int'(bus.pending), int'(m.pend));
         if (car_cf != int'(bus.target_floor)) begin
            mv++;
            if (mv == 3) begin
               car_cf += (int'(bus.target_floor) > car_cf) ? 1 : -1;
               mv = 0;
            end
         end else mv = 0;
         bus.current_floor = 4'(car_cf);
      end
   endtask

   task automatic press(input logic [NF-1:0] b);
      bus.call_btn = b;
      tick();
      bus.call_btn = '0;
   endtask

   task automatic teleport(input int f);
      car_cf = f; mv = 0;
      bus.current_floor = 4'(f);
      tick(4);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      tick(3);
      while ((bus.busy || bus.door_open) && n < budget) begin tick(); n++; end
      check({name, "_done"}, int'(bus.busy), 0);
   endtask

   task automatic chk_seq(input string name, input int q[$], input int base, input int exp[$]);
      check({name, "_count"}, q.size() - base, exp.size());
      foreach (exp[i]) if (base + i < q.size()) check(name, q[base + i], exp[i]);
   endtask

   initial begin
      int sb, lb, n;
      rst_n = 1'b1;
      bus.call_btn = '0;
      bus.current_floor = '0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_target",  int'(bus.target_floor), 0);
      check("rst_busy",    int'(bus.busy), 0);
      check("rst_door",    int'(bus.door_open), 0);
      check("rst_pending", int'(bus.pending), 0);
      check("rst_dir_up",  int'(bus.dir_up), 1);
      tick(3);
      rst_n = 1'b1;
      tick(20);
      check("idle_target",  int'(bus.target_floor), 0);
      check("idle_busy",    int'(bus.busy), 0);
      check("idle_pending", int'(bus.pending), 0);

      // Single call from floor 0 to floor 3.
      sb = stops.size(); lb = lens.size();
      press(6'b001000);
      check("single_pending", int'(bus.pending), 6'b001000);
      tick();
      check("single_target", int'(bus.target_floor), 3);
      check("single_dir_up", int'(bus.dir_up), 1);
      wait_done("single", 200);
      chk_seq("single_stops", stops, sb, '{3});
      chk_seq("single_len", lens, lb, '{4});
      check("single_cleared", int'(bus.pending), 0);

      // LOOK sweep from floor 2 heading up with calls {0,4,5}.
      teleport(2);
      sb = stops.size(); lb = lens.size();
      press(6'b110001);
      wait_done("look", 400);
      chk_seq("look_stops", stops, sb, '{4, 5, 0});
      chk_seq("look_len", lens, lb, '{4, 4, 4});
      check("look_dir_up", int'(bus.dir_up), 0);

      // Retarget 0->5 leg to floor 3 once the car reaches floor 1.
      sb = stops.size();
      press(6'b100000);
      n = 0;
      while (car_cf != 1 && n < 100) begin tick(); n++; end
      press(6'b001000);
      check("retarget_pending", int'(bus.pending), 6'b101000);
      tick();
      check("retarget_target", int'(bus.target_floor), 3);
      wait_done("retarget", 400);
      chk_seq("retarget_stops", stops, sb, '{3, 5});

      // Here-request at floor 2, then a re-press on dwell cycle 3.
      teleport(2);
      sb = stops.size(); lb = lens.size();
      press(6'b000100);
      check("here_pending_set", int'(bus.pending), 6'b000100);
      tick();
      check("here_pending_clr", int'(bus.pending), 0);
      check("here_door", int'(bus.door_open), 1);
      tick(2);
      press(6'b000100);
      wait_done("absorb", 200);
      chk_seq("absorb_stops", stops, sb, '{2});
      chk_seq("absorb_len", lens, lb, '{7});

      // Asynchronous reset in the middle of a dwell with calls outstanding.
      press(6'b000100);
      tick();
      press(6'b010010);
      check("pre_rst_pending", int'(bus.pending), 6'b010010);
      check("pre_rst_door", int'(bus.door_open), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_door",    int'(bus.door_open), 0);
      check("async_pending", int'(bus.pending), 0);
      check("async_busy",    int'(bus.busy), 0);
      tick(2);
      rst_n = 1'b1;
      #1;
      check("post_rst_target", int'(bus.target_floor), 0);
      check("post_rst_dir_up", int'(bus.dir_up), 1);
      tick(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
